// File: rtl/exec_mem_unit.sv
// Execute/memory slice of a single-cycle DLX-style datapath: sign extender,
// combinational ALU and a byte-addressed big-endian data memory with wrap-around.
module exec_mem_unit #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] imm16,
  output logic [31:0] ext_imm,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  input  logic [5:0]  alu_ctrl,
  output logic [31:0] alu_result,
  input  logic        mem_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata
);

  localparam int AW = $clog2(MEM_BYTES);

  localparam logic [5:0] OP_ADD  = 6'h00, OP_SUB  = 6'h01, OP_AND  = 6'h02;
  localparam logic [5:0] OP_OR   = 6'h03, OP_SLL  = 6'h04, OP_SRL  = 6'h05;
  localparam logic [5:0] OP_SRA  = 6'h06, OP_XOR  = 6'h08;
  localparam logic [5:0] OP_SEQ  = 6'h20, OP_SNE  = 6'h21, OP_SLT  = 6'h22;
  localparam logic [5:0] OP_SGT  = 6'h23, OP_SLE  = 6'h24, OP_SGE  = 6'h25;
  localparam logic [5:0] OP_SLTU = 6'h2A, OP_SGTU = 6'h2B, OP_SLEU = 6'h2C;
  localparam logic [5:0] OP_SGEU = 6'h2D;

  localparam logic [1:0] SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b11;

  logic [4:0]    shamt;
  logic [AW-1:0] a0, a1, a2, a3;
  logic [7:0]    mem_q [MEM_BYTES];
  logic [7:0]    mem_d [MEM_BYTES];

  assign ext_imm = {{16{imm16[15]}}, imm16};
  assign shamt   = alu_b[4:0];

  // NOTE: every output of a combinational block gets a default before the case,
  // so codes not listed can never leave the result unassigned (no latch).
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_XOR:  alu_result = alu_a ^ alu_b;
      OP_SLL:  alu_result = alu_a << shamt;
      OP_SRL:  alu_result = alu_a >> shamt;
      OP_SRA:  alu_result = $signed(alu_a) >>> shamt;
      OP_SEQ:  alu_result = {31'b0, alu_a == alu_b};
      OP_SNE:  alu_result = {31'b0, alu_a != alu_b};
      OP_SLT:  alu_result = {31'b0, $signed(alu_a) <  $signed(alu_b)};
      OP_SGT:  alu_result = {31'b0, $signed(alu_a) >  $signed(alu_b)};
      OP_SLE:  alu_result = {31'b0, $signed(alu_a) <= $signed(alu_b)};
      OP_SGE:  alu_result = {31'b0, $signed(alu_a) >= $signed(alu_b)};
      OP_SLTU: alu_result = {31'b0, alu_a <  alu_b};
      OP_SGTU: alu_result = {31'b0, alu_a >  alu_b};
      OP_SLEU: alu_result = {31'b0, alu_a <= alu_b};
      OP_SGEU: alu_result = {31'b0, alu_a >= alu_b};
      default: alu_result = '0;
    endcase
  end

  // Byte lanes wrap naturally because the index is only AW bits wide.
  assign a0 = alu_result[AW-1:0];
  assign a1 = a0 + AW'(1);
  assign a2 = a0 + AW'(2);
  assign a3 = a0 + AW'(3);

  assign mem_rdata = {mem_q[a0], mem_q[a1], mem_q[a2], mem_q[a3]};

  always_comb begin
    mem_d = mem_q;
    if (mem_wr) begin
      case (data_size)
        SZ_WORD: begin
          mem_d[a0] = mem_wdata[31:24];
          mem_d[a1] = mem_wdata[23:16];
          mem_d[a2] = mem_wdata[15:8];
          mem_d[a3] = mem_wdata[7:0];
        end
        SZ_HALF: begin
          mem_d[a0] = mem_wdata[15:8];
          mem_d[a1] = mem_wdata[7:0];
        end
        SZ_BYTE: mem_d[a0] = mem_wdata[7:0];
        default: ;
      endcase
    end
  end

  // NOTE: the memory is built from flops rather than a RAM macro because every
  // byte must clear asynchronously on reset; sequential state uses <= only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_BYTES; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_exec_mem_unit.sv
// Self-checking bench for exec_mem_unit: directed corner cases plus randomized
// ALU and memory traffic compared against a byte-array reference model.
module tb_exec_mem_unit;

  localparam int N = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] imm16;
  logic [31:0] ext_imm;
  logic [31:0] alu_a, alu_b;
  logic [5:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        mem_wr;
  logic [1:0]  data_size;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0] mm [N];

  exec_mem_unit #(.MEM_BYTES(N)) dut (
    .clk(clk), .reset(reset), .imm16(imm16), .ext_imm(ext_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .mem_wr(mem_wr), .data_size(data_size), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [15:0] v);
    return (v >= 16'h8000) ? (32'(v) + 32'hFFFF_0000) : 32'(v);
  endfunction

  // Signed order is obtained by flipping the sign bit and comparing unsigned.
  function automatic logic [31:0] ref_alu(input logic [5:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] sa, sb, fill;
    int unsigned s;
    sa = a ^ 32'h8000_0000;
    sb = b ^ 32'h8000_0000;
    s  = b % 32;
    fill = a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0;
    case (c)
      6'h00: return a + b;
      6'h01: return a + ~b + 32'd1;
      6'h02: return a & b;
      6'h03: return a | b;
      6'h08: return a ^ b;
      6'h04: return 32'(64'(a) * (64'd1 << s));
      6'h05: return a / (32'd1 << s);
      6'h06: return (a >> s) | fill;
      6'h20: return (a == b) ? 32'd1 : 32'd0;
      6'h21: return (a != b) ? 32'd1 : 32'd0;
      6'h22: return (sa <  sb) ? 32'd1 : 32'd0;
      6'h23: return (sa >  sb) ? 32'd1 : 32'd0;
      6'h24: return (sa <= sb) ? 32'd1 : 32'd0;
      6'h25: return (sa >= sb) ? 32'd1 : 32'd0;
      6'h2A: return (a <  b) ? 32'd1 : 32'd0;
      6'h2B: return (a >  b) ? 32'd1 : 32'd0;
      6'h2C: return (a <= b) ? 32'd1 : 32'd0;
      6'h2D: return (a >= b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_word(input int unsigned addr);
    int unsigned a;
    a = addr % N;
    return {mm[a], mm[(a + 1) % N], mm[(a + 2) % N], mm[(a + 3) % N]};
  endfunction

  task automatic model_store(input int unsigned addr, input logic [1:0] sz,
                             input logic [31:0] d);
    int unsigned a;
    a = addr % N;
    if (sz == 2'b11) begin
      mm[a] = d[31:24]; mm[(a + 1) % N] = d[23:16];
      mm[(a + 2) % N] = d[15:8]; mm[(a + 3) % N] = d[7:0];
    end else if (sz == 2'b01) begin
      mm[a] = d[15:8]; mm[(a + 1) % N] = d[7:0];
    end else if (sz == 2'b00) begin
      mm[a] = d[7:0];
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) mm[i] = 8'h00;
  endtask

  task automatic alu_op(input string tag, input logic [5:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    alu_ctrl = c; alu_a = a; alu_b = b;
    #1;
    check(tag, alu_result, exp);
  endtask

  task automatic read_at(input string tag, input int unsigned addr, input logic [31:0] exp);
    alu_ctrl = 6'h00; alu_a = 32'(addr); alu_b = 32'h0;
    #1;
    check(tag, mem_rdata, exp);
  endtask

  // Address is formed by the ALU as a+b; old data is checked before the edge,
  // new data after it.
  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] sz, input logic [31:0] d);
    int unsigned addr;
    addr = 32'(a + b) % N;
    @(negedge clk);
    alu_ctrl = 6'h00; alu_a = a; alu_b = b;
    data_size = sz; mem_wdata = d; mem_wr = 1'b1;
    #1;
    check({tag, "_pre"}, mem_rdata, model_word(addr));
    @(posedge clk);
    #1;
    mem_wr = 1'b0;
    model_store(addr, sz, d);
    check({tag, "_post"}, mem_rdata, model_word(addr));
  endtask

  logic [5:0] valid_codes [18];

  initial begin
    valid_codes = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h08, 6'h04, 6'h05, 6'h06, 6'h20,
                    6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h2B, 6'h2C, 6'h2D};
    reset = 1'b0; imm16 = '0; alu_a = '0; alu_b = '0; alu_ctrl = '0;
    mem_wr = 1'b0; data_size = 2'b11; mem_wdata = '0;
    model_clear();

    // Memory written to nonzero before reset is exercised later; here just reset.
    repeat (2) @(posedge clk);
    #1;
    read_at("rst_rd0", 0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    read_at("post_rst_rd8", 8, 32'h0);

    imm16 = 16'h7FFF; #1; check("sext_7fff", ext_imm, 32'h0000_7FFF);
    imm16 = 16'h8000; #1; check("sext_8000", ext_imm, 32'hFFFF_8000);
    imm16 = 16'hFFFF; #1; check("sext_ffff", ext_imm, 32'hFFFF_FFFF);

    alu_op("add_wrap", 6'h00, 32'hFFFF_FFFF, 32'd1, 32'h0);
    alu_op("sub_wrap", 6'h01, 32'h0, 32'd1, 32'hFFFF_FFFF);
    alu_op("and", 6'h02, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
    alu_op("or",  6'h03, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
    alu_op("xor", 6'h08, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);
    alu_op("sll", 6'h04, 32'h8000_0001, 32'h21, 32'h0000_0002);
    alu_op("srl", 6'h05, 32'h8000_0001, 32'h21, 32'h4000_0000);
    alu_op("sra", 6'h06, 32'h8000_0001, 32'h21, 32'hC000_0000);
    alu_op("slt",  6'h22, 32'hFFFF_FFFF, 32'd1, 32'd1);
    alu_op("sltu", 6'h2A, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu_op("sgt",  6'h23, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu_op("sgtu", 6'h2B, 32'hFFFF_FFFF, 32'd1, 32'd1);
    alu_op("seq", 6'h20, 32'd5, 32'd5, 32'd1);
    alu_op("sne", 6'h21, 32'd5, 32'd5, 32'd0);
    alu_op("sle", 6'h24, 32'd5, 32'd5, 32'd1);
    alu_op("sge", 6'h25, 32'd5, 32'd5, 32'd1);
    alu_op("unused_3f", 6'h3F, 32'h1234_5678, 32'h1, 32'd0);

    do_write("wr_word8", 32'd8, 32'd0, 2'b11, 32'h1122_3344);
    read_at("rd8_word", 8, 32'h1122_3344);
    do_write("wr_byte9", 32'd9, 32'd0, 2'b00, 32'h0000_00AA);
    read_at("rd8_byte", 8, 32'h11AA_3344);
    do_write("wr_half10", 32'd10, 32'd0, 2'b01, 32'h0000_BEEF);
    read_at("rd8_half", 8, 32'h11AA_BEEF);
    read_at("rd10_half", 10, 32'hBEEF_0000);
    do_write("wr_reserved", 32'd8, 32'd0, 2'b10, 32'hDEAD_BEEF);
    read_at("rd8_reserved", 8, 32'h11AA_BEEF);
    do_write("wr_wrap", 32'(N - 2), 32'd0, 2'b11, 32'hCAFE_BABE);
    read_at("rd_wrap0", 0, 32'hBABE_0000);
    read_at("rd_wrap_hi", N - 2, 32'hCAFE_BABE);

    // Randomized mix of ALU operations, extender values and memory traffic.
    for (int it = 0; it < 300; it++) begin
      int unsigned kind;
      logic [31:0] ra, rb, rd;
      logic [5:0]  rc;
      kind = $urandom_range(0, 3);
      ra = $urandom(); rb = $urandom(); rd = $urandom();
      if ($urandom_range(0, 3) == 0) rb = rb & 32'h3F;
      if (kind == 0) begin
        rc = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63))
                                         : valid_codes[$urandom_range(0, 17)];
        alu_op($sformatf("rnd_alu_%02h", rc), rc, ra, rb, ref_alu(rc, ra, rb));
        imm16 = rd[15:0]; #1;
        check("rnd_sext", ext_imm, ref_ext(rd[15:0]));
      end else if (kind == 1) begin
        do_write("rnd_wr", ra, rb, 2'($urandom_range(0, 3)), rd);
      end else begin
        read_at("rnd_rd", ra % N, model_word(ra % N));
      end
    end

    // Mid-run asynchronous reset: clears all bytes, blocks writes, ALU unaffected.
    do_write("pre_rst_fill", 32'd100, 32'd0, 2'b11, 32'h5A5A_A5A5);
    @(negedge clk);
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    check("midrst_rd_async", mem_rdata, 32'h0);
    alu_op("midrst_alu", 6'h01, 32'd10, 32'd3, 32'd7);
    alu_ctrl = 6'h00; alu_a = 32'd100; alu_b = 32'd0;
    data_size = 2'b11; mem_wdata = 32'hFFFF_FFFF; mem_wr = 1'b1;
    @(posedge clk);
    #1;
    mem_wr = 1'b0;
    check("midrst_wr_blocked", mem_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < N; i += 4) read_at("midrst_all_zero", i, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
